// File: rtl/king_scsi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : king_scsi_pkg
// Brief   : Shared types and constants for the KING SCSI data-phase engine.
// Revision: 1.0 - initial release
// ============================================================================
package king_scsi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_ACK_ON   = 3'd2,
    ST_ACK_OFF  = 3'd3,
    ST_FINISH   = 3'd4
  } king_xfer_state_t;

  localparam logic DIR_RX = 1'b1;
  localparam logic DIR_TX = 1'b0;

  localparam int c_ACK_ASSERT_CYC_DFLT = 2;
  localparam int c_ACK_NEGATE_CYC_DFLT = 2;

endpackage
`default_nettype wire

// File: rtl/king_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : king_sync_fifo
// Brief   : First-word fall-through synchronous FIFO with exact occupancy.
// Revision: 1.0 - initial release
// ============================================================================
module king_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESn,
  input  logic                     i_ce,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == c_LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_ce & i_push & ~o_full;
  assign w_do_pop  = i_ce & i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + c_LW'(w_do_push) - c_LW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/king_scsi_xfer.sv
`default_nettype none
// ============================================================================
// Module  : king_scsi_xfer
// Brief   : SCSI data-phase REQ/ACK transfer engine between bus and byte FIFO.
//           Optional phase check: define KING_SCSI_XFER_PHASE_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module king_scsi_xfer
  import king_scsi_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 16,
  parameter int ACK_ASSERT_CYC = c_ACK_ASSERT_CYC_DFLT,
  parameter int ACK_NEGATE_CYC = c_ACK_NEGATE_CYC_DFLT
) (
  input  logic                          CLK,
  input  logic                          RESn,
  input  logic                          CE,
  input  logic                          START,
  input  logic                          DIR,
  input  logic [CNT_W-1:0]              LEN,
  input  logic                          ABORT,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  output logic [CNT_W-1:0]              CNT_REM,
  input  logic                          FIFO_RD,
  output logic [7:0]                    FIFO_RDATA,
  input  logic                          FIFO_WR,
  input  logic [7:0]                    FIFO_WDATA,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LVL,
  input  logic [7:0]                    SCSI_DI,
  output logic [7:0]                    SCSI_DO,
  output logic                          SCSI_DOE,
  output logic                          SCSI_ACKn,
  input  logic                          SCSI_REQn,
  input  logic                          SCSI_IOn
);

  king_xfer_state_t r_state, w_state_nxt;
  logic             r_req_q;
  logic             r_dir;
  logic             r_err;
  logic             r_abort_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_tmr;
  logic             w_full, w_empty, w_ready, w_phase_err;
  logic             w_ack_done, w_neg_done, w_err_set;
  logic             w_eng_push, w_eng_pop, w_busy, w_rx_active, w_tx_active;
  logic             w_fifo_push, w_fifo_pop;
  logic [7:0]       w_push_data, w_head;

  assign w_busy      = (r_state == ST_WAIT_REQ) || (r_state == ST_ACK_ON) ||
                       (r_state == ST_ACK_OFF);
  assign w_rx_active = w_busy && (r_dir == DIR_RX);
  assign w_tx_active = w_busy && (r_dir == DIR_TX);
  assign w_ready     = (r_dir == DIR_RX) ? ~w_full : ~w_empty;
  assign w_ack_done  = (r_tmr >= 4'(ACK_ASSERT_CYC - 1)) && !r_req_q;
  assign w_neg_done  = (r_tmr >= 4'(ACK_NEGATE_CYC - 1));

`ifdef KING_SCSI_XFER_PHASE_CHK_EN
  // SCSI_IOn low means target->initiator, which must match a receive.
  assign w_phase_err = r_req_q && (SCSI_IOn == r_dir);
`else
  assign w_phase_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_eng_push  = 1'b0;
    w_eng_pop   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: if (START) w_state_nxt = ST_WAIT_REQ;
      ST_WAIT_REQ: begin
        if (ABORT) begin
          w_state_nxt = ST_FINISH;
        end else if (w_phase_err) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (r_req_q && w_ready) begin
          w_state_nxt = ST_ACK_ON;
          w_eng_push  = (r_dir == DIR_RX);
        end
      end
      ST_ACK_ON: if (w_ack_done) begin
        w_state_nxt = ST_ACK_OFF;
        w_eng_pop   = (r_dir == DIR_TX);
      end
      ST_ACK_OFF: if (w_neg_done) begin
        w_state_nxt = ((r_cnt == '0) || r_abort_pend || ABORT) ? ST_FINISH : ST_WAIT_REQ;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_state      <= ST_IDLE;
      r_req_q      <= 1'b0;
      r_dir        <= DIR_TX;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_cnt        <= '0;
      r_tmr        <= '0;
    end else if (CE) begin
      r_state <= w_state_nxt;
      r_req_q <= ~SCSI_REQn;
      // Cycles spent in the current state, saturating.
      if (w_state_nxt != r_state) r_tmr <= '0;
      else if (r_tmr != 4'hF)     r_tmr <= r_tmr + 1'b1;
      if (r_state == ST_IDLE && START) begin
        r_cnt        <= LEN;
        r_dir        <= DIR;
        r_err        <= 1'b0;
        r_abort_pend <= 1'b0;
      end
      if (r_state == ST_ACK_ON && w_ack_done) r_cnt <= r_cnt - 1'b1;
      if (w_err_set) r_err <= 1'b1;
      if ((r_state == ST_ACK_ON || r_state == ST_ACK_OFF) && ABORT) r_abort_pend <= 1'b1;
    end
  end

  // The engine owns the push side on receive and the pop side on transmit.
  assign w_fifo_push = w_rx_active ? w_eng_push : FIFO_WR;
  assign w_push_data = w_rx_active ? SCSI_DI    : FIFO_WDATA;
  assign w_fifo_pop  = w_tx_active ? w_eng_pop  : FIFO_RD;

  king_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK         (CLK),
    .RESn        (RESn),
    .i_ce        (CE),
    .i_push      (w_fifo_push),
    .i_push_data (w_push_data),
    .i_pop       (w_fifo_pop),
    .o_head      (w_head),
    .o_level     (FIFO_LVL),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign BUSY       = w_busy;
  assign DONE       = (r_state == ST_FINISH);
  assign ERR        = r_err;
  assign CNT_REM    = r_cnt;
  assign FIFO_RDATA = w_head;
  assign SCSI_DO    = w_tx_active ? w_head : 8'h00;
  assign SCSI_DOE   = w_tx_active & SCSI_IOn;
  assign SCSI_ACKn  = (r_state != ST_ACK_ON);

endmodule
`default_nettype wire

// File: tb/tb_king_scsi_xfer.sv
`default_nettype none
// Bench for king_scsi_xfer: table of whole transfers plus hand-built corner
// sequences; bytes are tracked through a queue from source to sink.
module tb_king_scsi_xfer;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;
  localparam int ACK_A      = 2;
  localparam int ACK_N      = 2;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             CLK = 1'b0, RESn = 1'b0, CE = 1'b1, START = 1'b0, DIR = 1'b0;
  logic             ABORT = 1'b0, FIFO_RD = 1'b0, FIFO_WR = 1'b0;
  logic             SCSI_REQn = 1'b1, SCSI_IOn = 1'b1;
  logic [CNT_W-1:0] LEN = '0;
  logic [7:0]       FIFO_WDATA = 8'h00, SCSI_DI = 8'h00;
  logic             BUSY, DONE, ERR, SCSI_DOE, SCSI_ACKn;
  logic [CNT_W-1:0] CNT_REM;
  logic [7:0]       FIFO_RDATA, SCSI_DO;
  logic [LVL_W-1:0] FIFO_LVL;

  king_scsi_xfer #(
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W),
    .ACK_ASSERT_CYC(ACK_A), .ACK_NEGATE_CYC(ACK_N)
  ) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .START(START), .DIR(DIR), .LEN(LEN),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CNT_REM(CNT_REM),
    .FIFO_RD(FIFO_RD), .FIFO_RDATA(FIFO_RDATA), .FIFO_WR(FIFO_WR),
    .FIFO_WDATA(FIFO_WDATA), .FIFO_LVL(FIFO_LVL), .SCSI_DI(SCSI_DI),
    .SCSI_DO(SCSI_DO), .SCSI_DOE(SCSI_DOE), .SCSI_ACKn(SCSI_ACKn),
    .SCSI_REQn(SCSI_REQn), .SCSI_IOn(SCSI_IOn)
  );

  always #5 CLK = ~CLK;

  int         n_vec = 0, n_err = 0;
  int         ack_run = 0, ack_min = 99, ack_n = 0, done_n = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       dir;
    int         n;
    logic [7:0] b [4];
    int         exp_lvl;
  } vec_t;
  vec_t tbl [4];

  always @(negedge CLK) begin
    if (DONE) done_n++;
    if (!SCSI_ACKn) begin
      if (ack_run == 0) ack_n++;
      ack_run++;
    end else if (ack_run > 0) begin
      if (ack_run < ack_min) ack_min = ack_run;
      ack_run = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic start_xfer(input logic d, input logic [CNT_W-1:0] n);
    DIR = d; LEN = n; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic cpu_push(input logic [7:0] d);
    FIFO_WDATA = d; FIFO_WR = 1'b1; sb.push_back(d);
    @(negedge CLK);
    FIFO_WR = 1'b0;
  endtask

  task automatic cpu_pop_check(input string nm);
    logic [7:0] e;
    e = 8'hxx;
    if (sb.size() > 0) e = sb.pop_front();
    check(nm, FIFO_RDATA, e);
    FIFO_RD = 1'b1;
    @(negedge CLK);
    FIFO_RD = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int t = 0;
    while (SCSI_ACKn != lvl && t < 40) begin @(negedge CLK); t++; end
    check(nm, SCSI_ACKn, lvl);
  endtask

  // One target-side REQ/ACK handshake; for transmit, checks the bus byte.
  task automatic target_byte(input logic [7:0] d, input logic rx);
    logic [7:0] e;
    @(negedge CLK);
    if (rx) begin SCSI_DI = d; sb.push_back(d); end
    SCSI_REQn = 1'b0;
    wait_ack(1'b0, "ack_assert");
    if (!rx) begin
      e = 8'hxx;
      if (sb.size() > 0) e = sb.pop_front();
      check("tx_doe", SCSI_DOE, 1'b1);
      check("tx_data", SCSI_DO, e);
    end
    SCSI_REQn = 1'b1;
    wait_ack(1'b1, "ack_negate");
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!DONE && t < 100) begin @(negedge CLK); t++; end
    check(nm, DONE, 1'b1);
    @(negedge CLK);
  endtask

  int d0, a0;

  initial begin
    tbl[0].dir = 1'b1; tbl[0].n = 4; tbl[0].b = '{8'h11, 8'h22, 8'h33, 8'h44}; tbl[0].exp_lvl = 4;
    tbl[1].dir = 1'b0; tbl[1].n = 3; tbl[1].b = '{8'hA5, 8'h5A, 8'hFF, 8'h00}; tbl[1].exp_lvl = 0;
    tbl[2].dir = 1'b1; tbl[2].n = 1; tbl[2].b = '{8'hC3, 8'h00, 8'h00, 8'h00}; tbl[2].exp_lvl = 1;
    tbl[3].dir = 1'b0; tbl[3].n = 2; tbl[3].b = '{8'h01, 8'h80, 8'h00, 8'h00}; tbl[3].exp_lvl = 0;

    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 0);     check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);       check("rst_cnt", CNT_REM, 0);
    check("rst_lvl", FIFO_LVL, 0);  check("rst_ackn", SCSI_ACKn, 1);
    check("rst_doe", SCSI_DOE, 0);  check("rst_do", SCSI_DO, 0);
    RESn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 4; i++) begin
      if (!tbl[i].dir) for (int k = 0; k < tbl[i].n; k++) cpu_push(tbl[i].b[k]);
      SCSI_IOn = tbl[i].dir ? 1'b0 : 1'b1;
      d0 = done_n; ack_min = 99;
      start_xfer(tbl[i].dir, CNT_W'(tbl[i].n));
      check("start_busy", BUSY, 1);
      for (int k = 0; k < tbl[i].n; k++) target_byte(tbl[i].b[k], tbl[i].dir);
      wait_done("xfer_done");
      check("xfer_cnt", CNT_REM, 0);
      check("xfer_lvl", FIFO_LVL, tbl[i].exp_lvl);
      check("xfer_done_once", done_n - d0, 1);
      check("xfer_ack_width", (ack_min >= ACK_A) ? 1 : 0, 1);
      check("xfer_busy_off", BUSY, 0);
      check("xfer_doe_off", SCSI_DOE, 0);
      check("xfer_err", ERR, 0);
      if (tbl[i].dir) for (int k = 0; k < tbl[i].n; k++) cpu_pop_check("rx_data");
      check("drain_lvl", FIFO_LVL, 0);
    end

    // FIFO full: receive stalls, one pop admits exactly one more byte.
    SCSI_IOn = 1'b0;
    start_xfer(1'b1, 16'd12);
    for (int k = 0; k < 8; k++) target_byte(8'h30 + 8'(k), 1'b1);
    @(negedge CLK);
    SCSI_DI = 8'h99; sb.push_back(8'h99); SCSI_REQn = 1'b0;
    repeat (10) @(negedge CLK);
    check("stall_ackn", SCSI_ACKn, 1);
    check("stall_lvl", FIFO_LVL, 8);
    check("stall_busy", BUSY, 1);
    a0 = ack_n;
    cpu_pop_check("stall_pop");
    wait_ack(1'b0, "unstall_ack");
    SCSI_REQn = 1'b1;
    wait_ack(1'b1, "unstall_neg");
    @(negedge CLK);
    SCSI_DI = 8'hEE; SCSI_REQn = 1'b0;
    repeat (10) @(negedge CLK);
    check("restall_lvl", FIFO_LVL, 8);
    check("restall_acks", ack_n - a0, 1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    wait_done("stall_abort_done");
    SCSI_REQn = 1'b1;
    check("stall_cnt", CNT_REM, 3);
    for (int k = 0; k < 8; k++) cpu_pop_check("stall_data");

    // Abort while ACK of byte 2 of 5 is asserted.
    a0 = ack_n;
    start_xfer(1'b1, 16'd5);
    target_byte(8'h61, 1'b1);
    @(negedge CLK);
    SCSI_DI = 8'h62; sb.push_back(8'h62); SCSI_REQn = 1'b0;
    wait_ack(1'b0, "abort_ack");
    ABORT = 1'b1; SCSI_REQn = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    wait_ack(1'b1, "abort_ack_neg");
    wait_done("abort_done");
    check("abort_cnt", CNT_REM, 3);
    SCSI_DI = 8'h63; SCSI_REQn = 1'b0;
    repeat (10) @(negedge CLK);
    check("abort_acks", ack_n - a0, 2);
    check("abort_busy", BUSY, 0);
    SCSI_REQn = 1'b1;
    cpu_pop_check("abort_data");
    cpu_pop_check("abort_data");

    // LEN = 0 means a full 2^CNT_W transfer: first byte wraps the count.
    start_xfer(1'b1, 16'd0);
    target_byte(8'h5C, 1'b1);
    check("len0_cnt", CNT_REM, 16'hFFFF);
    check("len0_busy", BUSY, 1);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    wait_done("len0_done");
    cpu_pop_check("len0_data");

`ifdef KING_SCSI_XFER_PHASE_CHK_EN
    a0 = ack_n;
    SCSI_IOn = 1'b1;
    start_xfer(1'b1, 16'd2);
    SCSI_REQn = 1'b0;
    wait_done("phase_done");
    check("phase_err", ERR, 1);
    check("phase_acks", ack_n - a0, 0);
    check("phase_lvl", FIFO_LVL, 0);
    SCSI_REQn = 1'b1;
    SCSI_IOn = 1'b0;
    start_xfer(1'b1, 16'd1);
    check("phase_err_clr", ERR, 0);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    wait_done("phase_clr_done");
`endif

    // Asynchronous reset during ACK_ON.
    SCSI_IOn = 1'b0;
    start_xfer(1'b1, 16'd2);
    @(negedge CLK);
    SCSI_DI = 8'h77; SCSI_REQn = 1'b0;
    wait_ack(1'b0, "rst_mid_ack");
    RESn = 1'b0;
    #1;
    check("rst_mid_ackn", SCSI_ACKn, 1);
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_lvl", FIFO_LVL, 0);
    @(negedge CLK);
    RESn = 1'b1; SCSI_REQn = 1'b1;
    sb.delete();
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/king_scsi_xfer.md
# king_scsi_xfer

Parametrised SCSI data-phase transfer engine for KING (HuC6272): moves a programmed byte count between the SCSI bus and a local byte FIFO using automatic REQ/ACK handshaking, in either direction. It replaces the single-byte, CPU-paced DMA path of the current KING SCSI register block. The KING register file drives START/LEN/DIR and drains or fills the FIFO; the engine owns SCSI_ACKn and the data-bus drivers during a transfer.

## Interface
- FIFO_DEPTH, 8: FIFO entries; power of two, range 2..64.
- CNT_W, 16: width of the byte counter; LEN = 0 means 2^CNT_W bytes.
- ACK_ASSERT_CYC, 2: minimum ACK assertion, in CE cycles, range 1..15.
- ACK_NEGATE_CYC, 2: minimum ACK negation before the next byte, in CE cycles, range 1..15.
- CLK  in  1  system clock.
- RESn  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; all state advances only when CE=1.
- START  in  1  single-cycle pulse; starts a transfer (ignored while BUSY).
- DIR  in  1  sampled at START; 1 = receive (target→KING), 0 = transmit.
- LEN  in  CNT_W  byte count, sampled at START.
- ABORT  in  1  pulse; ends the transfer after any ACK in progress completes.
- BUSY  out  1  transfer active.
- DONE  out  1  one-CE-cycle pulse when the transfer ends (normal or abort).
- ERR  out  1  sticky phase-mismatch flag, cleared by START.
- CNT_REM  out  CNT_W  bytes remaining.
- FIFO_RD  in  1  pop the receive byte; ignored when empty.
- FIFO_RDATA  out  8  FIFO head (first-word fall-through).
- FIFO_WR  in  1  push FIFO_WDATA; ignored when full.
- FIFO_WDATA  in  8  byte to push.
- FIFO_LVL  out  $clog2(FIFO_DEPTH)+1  occupancy.
- SCSI_DI  in  8  bus data in.
- SCSI_DO  out  8  bus data out.
- SCSI_DOE  out  1  drive enable for SCSI_DO.
- SCSI_ACKn  out  1  ACK, active low.
- SCSI_REQn  in  1  REQ, active low.
- SCSI_IOn  in  1  I/O phase line, active low (0 = target→initiator).

## Operation
- Reset values: BUSY=0, DONE=0, ERR=0, CNT_REM=0, FIFO empty, FIFO_LVL=0, SCSI_ACKn=1, SCSI_DOE=0, SCSI_DO=0.
- SCSI_REQn passes through one CE-qualified register (req_q); all decisions use req_q.
- States: IDLE, WAIT_REQ, ACK_ON, ACK_OFF, FINISH.
- IDLE: on START, load CNT_REM=LEN, latch DIR, clear ERR, and go to WAIT_REQ. The FIFO is not flushed.
- WAIT_REQ: when req_q=1 and the FIFO is ready, go to ACK_ON. Ready means not full for receive, and not empty for transmit. Stall indefinitely otherwise.
- Receive: on entry to ACK_ON, push SCSI_DI (sampled on the same edge as the req_q rise decision) into the FIFO.
- Transmit: SCSI_DO = FIFO head and SCSI_DOE = BUSY & ~DIR & SCSI_IOn. Pop on the ACK_ON→ACK_OFF transition.
- ACK_ON: SCSI_ACKn=0. Leave after at least ACK_ASSERT_CYC cycles AND req_q=0. On leaving, decrement CNT_REM.
- ACK_OFF: SCSI_ACKn=1 for ACK_NEGATE_CYC cycles. Then go to FINISH if CNT_REM=0 or an abort is pending; otherwise go to WAIT_REQ.
- FINISH: DONE=1 for one cycle, BUSY=0, then IDLE.
- ABORT: in WAIT_REQ, go straight to FINISH. In ACK_ON/ACK_OFF, latch as pending and honour at the end of ACK_OFF. In IDLE, ignored.
- Counter: CNT_W-bit with natural wrap. LEN=0 transfers 2^CNT_W bytes (decrement 0→all-ones).
- FIFO: a CPU FIFO_RD/FIFO_WR in the same cycle as an engine push/pop is legal. Level stays exact; a push and pop together leave the level unchanged.
- Async reset mid-transfer: ACK is negated immediately, the state machine returns to IDLE, and FIFO contents are lost.

## Timing
- START → BUSY=1 on the next CE edge.
- req_q rises → ACK_ON entered on the following CE edge. SCSI_ACKn is registered, so worst-case REQ-to-ACK is 2 CE cycles.
- Minimum byte period: 1 (WAIT_REQ) + ACK_ASSERT_CYC + ACK_NEGATE_CYC CE cycles.
- FIFO_RDATA is valid in the same cycle FIFO_LVL>0. A pop takes effect on the next edge.

## Configuration
- KING_SCSI_XFER_PHASE_CHK_EN defined: in WAIT_REQ, if req_q=1 and SCSI_IOn ≠ ~DIR (data phase disagrees with the transfer direction), set ERR and go to FINISH without acknowledging.
- Not defined: SCSI_IOn is used only for SCSI_DOE, and ERR is tied to 0.

## Structure
- Package king_scsi_pkg: state enum king_xfer_state_t, DIR_RX/DIR_TX constants, and the default values of ACK_ASSERT_CYC and ACK_NEGATE_CYC.
- Sub-module king_sync_fifo: parametrised depth/width, first-word fall-through, with level, full and empty outputs. It is instantiated once, and its direction is set per transfer.

## Test plan
- Receive 4 bytes (DIR=1, LEN=4): target presents 0x11,0x22,0x33,0x44 with REQ/ACK → FIFO holds them in order, CNT_REM=0, one DONE pulse, and ACK low ≥2 cycles per byte.
- Receive with FIFO_DEPTH=8, LEN=12, no CPU reads → engine stalls in WAIT_REQ with FIFO_LVL=8 and ACK high. Popping one byte → exactly one more byte is accepted.
- Transmit 3 bytes preloaded 0xA5,0x5A,0xFF with SCSI_IOn=1 → SCSI_DO shows each byte while SCSI_DOE=1. The FIFO empties and DONE fires.
- ABORT during ACK_ON of byte 2 of 5 → ACK completes normally, DONE fires, CNT_REM=3, and no further ACK.
- With KING_SCSI_XFER_PHASE_CHK_EN: DIR=1 and SCSI_IOn=1 when REQ asserts → ERR=1, DONE, and ACK never asserted.
- Assert RESn low while ACK_ON → SCSI_ACKn=1 and BUSY=0 immediately, FIFO_LVL=0.
